// File: rtl/pezaris_pkg.sv
// Shared constants, FSM state encoding and step-count helper for the Pezaris final CPA stage.
package pezaris_pkg;

    localparam int unsigned PEZ_N = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pez_state_e;

    // Number of RUN cycles needed to resolve n bits, chunk bits at a time.
    function automatic int unsigned pez_steps(input int unsigned n, input int unsigned chunk);
        if (chunk == 0) begin
            return 1;
        end
        return (n + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/pezaris_cpa_slice.sv
// Combinational CHUNK-bit ripple adder; lanes with lane_en low pass the carry through and emit 0.
module pezaris_cpa_slice #(
    parameter int unsigned CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic [CHUNK-1:0] lane_en,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_c,
    output logic             cout_c
);

    logic [CHUNK:0] cy;

    assign cy[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum_c[i]  = lane_en[i] & (a[i] ^ b[i] ^ cy[i]);
        assign cy[i + 1] = lane_en[i] ? ((a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]))
                                      : cy[i];
    end

    assign cout_c = cy[CHUNK];

endmodule

// File: rtl/pezaris_cpa_seq.sv
// Multi-cycle carry-propagate stage resolving the high product half CHUNK bits per cycle.
// Optional build macro PEZ_CPA_COUT_EN exposes the MSB-slice carry out as out_cout.
module pezaris_cpa_seq
    import pezaris_pkg::*;
#(
    parameter int unsigned N     = PEZ_N,
    parameter int unsigned CHUNK = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_u,
    input  logic [N-1:0]   in_c,
    input  logic           in_cin,
    input  logic [N-1:0]   in_lo,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef PEZ_CPA_COUT_EN
    output logic           out_cout,
`endif
    output logic [2*N-1:0] out_p
);

    localparam int unsigned STEPS = pez_steps(N, CHUNK);
    localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (CHUNK == 0 || CHUNK > N) begin : g_chunk_range
        $error("pezaris_cpa_seq: CHUNK must lie in 1..N");
    end

    pez_state_e      state_q, state_d;
    logic [N-1:0]    u_q, u_d;
    logic [N-1:0]    c_q, c_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    hi_q, hi_d;
    logic            carry_q, carry_d;
    logic [SW-1:0]   step_q, step_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

`ifdef PEZ_CPA_COUT_EN
    logic            cout_q, cout_d;
    assign out_cout = cout_q;
`else
    // Carry out of the MSB slice is simply not retained in this build.
`endif

    int unsigned     slice_base;
    logic [CHUNK-1:0] slice_a, slice_b, slice_en, slice_sum;
    logic            slice_cout;

    // Select the current CHUNK-wide window; lanes past bit N-1 are disabled.
    always_comb begin
        slice_base = 32'(step_q) * CHUNK;
        slice_a    = CHUNK'(u_q >> slice_base);
        slice_b    = CHUNK'(c_q >> slice_base);
        slice_en   = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            slice_en[i] = (slice_base + 32'(i)) < N;
        end
    end

    pezaris_cpa_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a       (slice_a),
        .b       (slice_b),
        .lane_en (slice_en),
        .cin     (carry_q),
        .sum_c   (slice_sum),
        .cout_c  (slice_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        c_d     = c_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        step_d  = step_q;
`ifdef PEZ_CPA_COUT_EN
        cout_d  = cout_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    u_d     = in_u;
                    // Top carry bit falls at weight 2^(2N) and is dropped by the truncation.
                    c_d     = N'({in_c, 1'b0});
                    lo_d    = in_lo;
                    carry_d = in_cin;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                hi_d    = (hi_q & ~(N'(slice_en) << slice_base)) | (N'(slice_sum) << slice_base);
                carry_d = slice_cout;
                if (step_q == SW'(STEPS - 1)) begin
                    state_d = DONE;
`ifdef PEZ_CPA_COUT_EN
                    cout_d  = slice_cout;
`endif
                end else begin
                    step_d = SW'(step_q + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            u_q         <= '0;
            c_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            carry_q     <= 1'b0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef PEZ_CPA_COUT_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            c_q         <= c_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            carry_q     <= carry_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef PEZ_CPA_COUT_EN
            cout_q      <= cout_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = {hi_q, lo_q};

endmodule

// File: tb/tb_pezaris_cpa_seq.sv
// Directed self-checking bench for pezaris_cpa_seq at N=7, CHUNK=2.
module tb_pezaris_cpa_seq;

    localparam int unsigned N = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_u, in_c, in_lo;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] out_p;
`ifdef PEZ_CPA_COUT_EN
    logic          out_cout;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pezaris_cpa_seq #(.N(7), .CHUNK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_u      (in_u),
        .in_c      (in_c),
        .in_cin    (in_cin),
        .in_lo     (in_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PEZ_CPA_COUT_EN
        .out_cout  (out_cout),
`endif
        .out_p     (out_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_u = '0; in_c = '0; in_cin = 1'b0; in_lo = '0;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_p !== 14'h0000) $display("FAIL reset_out_p got %h want 0000", out_p);
        else pass_cnt++;
`ifdef PEZ_CPA_COUT_EN
        total_cnt++;
        if (out_cout !== 1'b0) $display("FAIL reset_out_cout got %b want 0", out_cout);
        else pass_cnt++;
`endif
    endtask

    // Accept one vector, measure latency, check the product, then complete the handshake.
    task automatic run_op(input logic [6:0] u, input logic [6:0] c, input logic cin,
                          input logic [6:0] lo, input logic [13:0] exp_p,
                          input logic exp_cout, input string name);
        int lat;
        in_u = u; in_c = c; in_cin = cin; in_lo = lo; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_u = 7'h33; in_c = 7'h4C; in_cin = ~cin; in_lo = 7'h00;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL %s_busy in_ready got %b want 0", name, in_ready);
        else pass_cnt++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat !== 4) $display("FAIL %s_latency got %0d want 4", name, lat);
        else pass_cnt++;
        total_cnt++;
        if (out_p !== exp_p) $display("FAIL %s_out_p got %h want %h", name, out_p, exp_p);
        else pass_cnt++;
`ifdef PEZ_CPA_COUT_EN
        total_cnt++;
        if (out_cout !== exp_cout) $display("FAIL %s_out_cout got %b want %b", name, out_cout, exp_cout);
        else pass_cnt++;
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_carry_wrap();
        run_op(7'h7F, 7'h01, 1'b0, 7'h15, 14'h0095, 1'b1, "carry_wrap");
    endtask

    task automatic test_correction();
        run_op(7'h00, 7'h00, 1'b1, 7'h00, 14'h0080, 1'b0, "correction");
    endtask

    task automatic test_mixed();
        run_op(7'h2A, 7'h15, 1'b1, 7'h7F, 14'h2AFF, 1'b0, "mixed");
        run_op(7'h2A, 7'h55, 1'b1, 7'h7F, 14'h2AFF, 1'b0, "mixed_c6");
    endtask

    task automatic test_backpressure();
        int lat;
        in_u = 7'h2A; in_c = 7'h15; in_cin = 1'b1; in_lo = 7'h7F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL bp_wait out_valid got %b want 1", out_valid);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_p !== 14'h2AFF || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d out_valid=%b out_p=%h in_ready=%b want 1/2aff/0",
                         i, out_valid, out_p, in_ready);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 14'h2AFF)
            $display("FAIL bp_release in_ready=%b out_valid=%b out_p=%h want 1/0/2aff",
                     in_ready, out_valid, out_p);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        in_u = 7'h7F; in_c = 7'h01; in_cin = 1'b0; in_lo = 7'h15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_p !== 14'h0000 || in_ready !== 1'b1)
            $display("FAIL midrun_reset out_valid=%b out_p=%h in_ready=%b want 0/0000/1",
                     out_valid, out_p, in_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midrun_idle out_valid got %b want 0", out_valid);
        else pass_cnt++;
        run_op(7'h2A, 7'h15, 1'b1, 7'h7F, 14'h2AFF, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [13:0] got[$];
        int acc_cyc[$];
        logic acc;
        int n_acc;
        out_ready = 1'b1;
        in_u = 7'h7F; in_c = 7'h01; in_cin = 1'b0; in_lo = 7'h15; in_valid = 1'b1;
        n_acc = 0;
        for (int cyc = 0; cyc < 40 && got.size() < 2; cyc++) begin
            acc = in_ready & in_valid;
            tick();
            if (acc) begin
                acc_cyc.push_back(cyc);
                n_acc++;
                if (n_acc == 1) begin
                    in_u = 7'h2A; in_c = 7'h15; in_cin = 1'b1; in_lo = 7'h7F;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) got.push_back(out_p);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (acc_cyc.size() != 2) $display("FAIL b2b_accepts got %0d want 2", acc_cyc.size());
        else if (acc_cyc[1] - acc_cyc[0] != 6)
            $display("FAIL b2b_spacing got %0d want 6", acc_cyc[1] - acc_cyc[0]);
        else pass_cnt++;
        total_cnt++;
        if (got.size() != 2) $display("FAIL b2b_outputs got %0d want 2", got.size());
        else if (got[0] !== 14'h0095 || got[1] !== 14'h2AFF)
            $display("FAIL b2b_order got %h,%h want 0095,2aff", got[0], got[1]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_correction();
        test_mixed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
